// File: rtl/traffic_display_driver.sv
// Lamp LEDs, illegal-code flag and two-digit multiplexed 7-segment countdown display.
// Optional: define TRAFFIC_DISPLAY_LASTSEC_FLASH_EN to flash digits during the last green seconds.
module traffic_display_driver #(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned BLINK_DIV      = 12500000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       strt_clk,
  input  logic       reset_n,
  input  logic [2:0] light,
  input  logic [4:0] remaining_time,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       led_r,
  output logic       led_y,
  output logic       led_g,
  output logic       err
);

  localparam int unsigned RefW   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RefW-1:0]   RefMax   = RefW'(REFRESH_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);
  localparam logic [6:0] SegInv = {7{SEG_ACTIVE_LOW}};
  localparam logic [1:0] AnInv  = {2{SEG_ACTIVE_LOW}};

  logic [2:0]        light_q, light_prev_q;
  logic [4:0]        time_q;
  logic [RefW-1:0]   ref_cnt_q, ref_cnt_d;
  logic              digit_sel_q, digit_sel_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic [6:0]        seg_q, seg_d, seg_hi;
  logic [1:0]        an_q, an_d;
  logic              led_r_d, led_y_d, led_g_d, err_d;
  logic              led_r_q, led_y_q, led_g_q, err_q;
  logic              one_hot, resync;
  logic [1:0]        tens;
  logic [3:0]        units;

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  always_comb begin
    one_hot = (light_q == 3'b001) || (light_q == 3'b010) || (light_q == 3'b100);
    resync  = (light_q != light_prev_q);

    ref_cnt_d   = (ref_cnt_q == RefMax) ? '0 : ref_cnt_q + RefW'(1);
    digit_sel_d = digit_sel_q ^ (ref_cnt_q == RefMax);

    // A light change restarts the blink period lit, overriding a coincident wrap.
    blink_cnt_d   = blink_cnt_q + BlinkW'(1);
    blink_phase_d = blink_phase_q;
    if (resync) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (blink_cnt_q == BlinkMax) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end

    tens  = 2'd0;
    units = 4'(time_q);
    if (time_q >= 5'd30) begin
      tens  = 2'd3;
      units = 4'(time_q - 5'd30);
    end else if (time_q >= 5'd20) begin
      tens  = 2'd2;
      units = 4'(time_q - 5'd20);
    end else if (time_q >= 5'd10) begin
      tens  = 2'd1;
      units = 4'(time_q - 5'd10);
    end

    if (!one_hot) begin
      seg_hi = 7'b1000000;
    end else if (digit_sel_q) begin
      seg_hi = (tens == 2'd0) ? 7'b0000000 : seg_pat({2'b00, tens});
    end else begin
      seg_hi = seg_pat(units);
    end
`ifdef TRAFFIC_DISPLAY_LASTSEC_FLASH_EN
    if (one_hot && (light_q == 3'b100) && (time_q <= 5'd3) && !blink_phase_d) begin
      seg_hi = 7'b0000000;
    end
`endif

    seg_d   = seg_hi ^ SegInv;
    an_d    = (digit_sel_q ? 2'b10 : 2'b01) ^ AnInv;
    err_d   = ~one_hot;
    led_r_d = (light_q == 3'b001);
    led_y_d = (light_q == 3'b010) && blink_phase_d;
    led_g_d = (light_q == 3'b100);
  end

  always_ff @(posedge strt_clk or negedge reset_n) begin
    if (!reset_n) begin
      light_q       <= 3'b000;
      light_prev_q  <= 3'b000;
      time_q        <= 5'd0;
      ref_cnt_q     <= '0;
      digit_sel_q   <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      seg_q         <= SegInv;
      an_q          <= AnInv;
      led_r_q       <= 1'b0;
      led_y_q       <= 1'b0;
      led_g_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      light_q       <= light;
      light_prev_q  <= light_q;
      time_q        <= remaining_time;
      ref_cnt_q     <= ref_cnt_d;
      digit_sel_q   <= digit_sel_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      led_r_q       <= led_r_d;
      led_y_q       <= led_y_d;
      led_g_q       <= led_g_d;
      err_q         <= err_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign led_r = led_r_q;
  assign led_y = led_y_q;
  assign led_g = led_g_q;
  assign err   = err_q;

endmodule

// File: tb/tb_traffic_display_driver.sv
// Randomized bench for traffic_display_driver against a history-based reference model.
module tb_traffic_display_driver;

  localparam int RefDiv   = 4;
  localparam int BlinkDiv = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] light = 3'b000;
  logic [4:0] remaining_time = 5'd0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       led_r, led_y, led_g, err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_edges  = 0;
  logic [2:0] hist_l [0:4095];
  logic [4:0] hist_t [0:4095];

  traffic_display_driver #(
    .REFRESH_DIV   (RefDiv),
    .BLINK_DIV     (BlinkDiv),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .strt_clk      (clk),
    .reset_n       (reset_n),
    .light         (light),
    .remaining_time(remaining_time),
    .seg           (seg),
    .an            (an),
    .led_r         (led_r),
    .led_y         (led_y),
    .led_g         (led_g),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Inputs seen at edge k (k >= 1 since reset release) are kept in hist_*[k].
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_edges <= 0;
    end else begin
      hist_l[n_edges + 1] <= light;
      hist_t[n_edges + 1] <= remaining_time;
      n_edges <= n_edges + 1;
    end
  end

  function automatic logic [2:0] hl(input int k);
    if (k <= 0) return 3'b000;
    return hist_l[k];
  endfunction

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Expected outputs after the n-th edge since reset release.
  task automatic model(input int n, output logic [6:0] s, output logic [1:0] a,
                       output logic r, output logic y, output logic g, output logic e);
    logic [2:0] l;
    int t, rs, sel;
    bit ph, oh;
    logic [6:0] hi;
    if (n == 0) begin
      s = 7'h7F; a = 2'b11; r = 1'b0; y = 1'b0; g = 1'b0; e = 1'b0;
      return;
    end
    l = hl(n - 1);
    t = (n - 1 <= 0) ? 0 : int'(hist_t[n - 1]);
    rs = 0;
    for (int k = n; k >= 2; k--) begin
      if (hl(k - 1) != hl(k - 2)) begin
        rs = k;
        break;
      end
    end
    ph  = (((n - rs) / BlinkDiv) % 2) == 0;
    sel = ((n - 1) / RefDiv) % 2;
    oh  = (l == 3'b001) || (l == 3'b010) || (l == 3'b100);
    e = !oh;
    r = (l == 3'b001);
    g = (l == 3'b100);
    y = (l == 3'b010) && ph;
    if (!oh) hi = 7'b1000000;
    else if (sel == 1) hi = (t < 10) ? 7'b0000000 : pat(t / 10);
    else hi = pat(t % 10);
`ifdef TRAFFIC_DISPLAY_LASTSEC_FLASH_EN
    if (oh && l == 3'b100 && t <= 3 && !ph) hi = 7'b0000000;
`endif
    s = ~hi;
    a = (sel == 1) ? 2'b01 : 2'b10;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    light = 3'b100;
    remaining_time = 5'd25;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 6;
    if (seg !== 7'h7F) $display("FAIL reset_seg got %b want %b", seg, 7'h7F); else n_pass++;
    if (an !== 2'b11) $display("FAIL reset_an got %b want 11", an); else n_pass++;
    if (led_r !== 1'b0) $display("FAIL reset_led_r got %b want 0", led_r); else n_pass++;
    if (led_y !== 1'b0) $display("FAIL reset_led_y got %b want 0", led_y); else n_pass++;
    if (led_g !== 1'b0) $display("FAIL reset_led_g got %b want 0", led_g); else n_pass++;
    if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
    #1 reset_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      logic [6:0] es; logic [1:0] ea; logic er, ey, eg, ee;
      @(posedge clk); #1;
      model(n_edges, es, ea, er, ey, eg, ee);
      n_checks++;
      if (an !== ea) $display("FAIL scan_an cyc %0d got %b want %b", i, an, ea); else n_pass++;
      if (i == 1) begin
        n_checks++;
        if (an !== 2'b10) $display("FAIL first_an got %b want 10", an); else n_pass++;
      end
    end
  endtask

  task automatic test_two_digit();
    light = 3'b001;
    remaining_time = 5'd25;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      logic [6:0] es; logic [1:0] ea; logic er, ey, eg, ee;
      @(posedge clk); #1;
      model(n_edges, es, ea, er, ey, eg, ee);
      n_checks += 3;
      if (led_r !== er) $display("FAIL two_led_r n %0d got %b want %b", n_edges, led_r, er);
      else n_pass++;
      if (seg !== es) $display("FAIL two_seg n %0d got %b want %b", n_edges, seg, es);
      else n_pass++;
      if (an !== ea) $display("FAIL two_an n %0d got %b want %b", n_edges, an, ea);
      else n_pass++;
      if (n_edges >= 2) begin
        n_checks++;
        if (seg !== ((ea == 2'b10) ? 7'b0010010 : 7'b0100100))
          $display("FAIL two_digit_pat n %0d got %b an %b", n_edges, seg, ea);
        else n_pass++;
      end
    end
  endtask

  task automatic test_tens_blank();
    light = 3'b001;
    remaining_time = 5'd7;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      logic [6:0] es; logic [1:0] ea; logic er, ey, eg, ee;
      @(posedge clk); #1;
      model(n_edges, es, ea, er, ey, eg, ee);
      n_checks++;
      if (seg !== es) $display("FAIL blank_seg n %0d got %b want %b", n_edges, seg, es);
      else n_pass++;
      if (n_edges >= 2) begin
        n_checks++;
        if (seg !== ((ea == 2'b10) ? 7'b1111000 : 7'h7F))
          $display("FAIL blank_pat n %0d got %b an %b", n_edges, seg, ea);
        else n_pass++;
      end
    end
  endtask

  task automatic test_yellow_blink();
    int sw;
    light = 3'b100;
    remaining_time = 5'd12;
    do_reset();
    repeat (13) @(posedge clk);
    #1 light = 3'b010;
    sw = n_edges;
    for (int i = 0; i < 40; i++) begin
      logic [6:0] es; logic [1:0] ea; logic er, ey, eg, ee;
      @(posedge clk); #1;
      model(n_edges, es, ea, er, ey, eg, ee);
      n_checks += 2;
      if (led_y !== ey) $display("FAIL blink_led_y n %0d got %b want %b", n_edges, led_y, ey);
      else n_pass++;
      if (led_g !== eg) $display("FAIL blink_led_g n %0d got %b want %b", n_edges, led_g, eg);
      else n_pass++;
      if (n_edges == sw + 2) begin
        n_checks++;
        if (led_y !== 1'b1) $display("FAIL resync_lit got %b want 1", led_y); else n_pass++;
      end
    end
  endtask

  task automatic test_illegal();
    light = 3'b011;
    remaining_time = 5'd9;
    for (int i = 1; i <= 8; i++) begin
      logic [6:0] es; logic [1:0] ea; logic er, ey, eg, ee;
      @(posedge clk); #1;
      model(n_edges, es, ea, er, ey, eg, ee);
      n_checks += 3;
      if (err !== ee) $display("FAIL ill_err n %0d got %b want %b", n_edges, err, ee);
      else n_pass++;
      if ({led_r, led_y, led_g} !== {er, ey, eg})
        $display("FAIL ill_leds n %0d got %b want %b", n_edges, {led_r, led_y, led_g},
                 {er, ey, eg});
      else n_pass++;
      if (seg !== es) $display("FAIL ill_seg n %0d got %b want %b", n_edges, seg, es);
      else n_pass++;
      if (i >= 2) begin
        n_checks++;
        if ({err, seg} !== {1'b1, 7'b0111111})
          $display("FAIL ill_dash got err %b seg %b want 1 0111111", err, seg);
        else n_pass++;
      end
    end
    light = 3'b100;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i >= 2) begin
        n_checks++;
        if (err !== 1'b0) $display("FAIL ill_clear cyc %0d got %b want 0", i, err);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    int hold, sel;
    do_reset();
    for (int blk = 0; blk < 40; blk++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 2) light = 3'(1 << sel);
      else if (sel <= 6) light = 3'b010;
      else light = 3'($urandom_range(0, 7));
      remaining_time = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3))
                                                   : 5'($urandom_range(0, 31));
      hold = int'($urandom_range(1, 20));
      for (int i = 0; i < hold; i++) begin
        logic [6:0] es; logic [1:0] ea; logic er, ey, eg, ee;
        @(posedge clk); #1;
        model(n_edges, es, ea, er, ey, eg, ee);
        n_checks += 3;
        if ({seg, an} !== {es, ea})
          $display("FAIL rnd_disp n %0d got %b/%b want %b/%b", n_edges, seg, an, es, ea);
        else n_pass++;
        if ({led_r, led_y, led_g} !== {er, ey, eg})
          $display("FAIL rnd_leds n %0d got %b want %b", n_edges, {led_r, led_y, led_g},
                   {er, ey, eg});
        else n_pass++;
        if (err !== ee) $display("FAIL rnd_err n %0d got %b want %b", n_edges, err, ee);
        else n_pass++;
      end
    end
  endtask

  task automatic test_async_reset();
    light = 3'b001;
    remaining_time = 5'd25;
    do_reset();
    repeat (7) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    n_checks += 3;
    if (seg !== 7'h7F) $display("FAIL async_seg got %b want 1111111", seg); else n_pass++;
    if (an !== 2'b11) $display("FAIL async_an got %b want 11", an); else n_pass++;
    if ({led_r, led_y, led_g, err} !== 4'b0000)
      $display("FAIL async_flags got %b want 0000", {led_r, led_y, led_g, err});
    else n_pass++;
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      logic [6:0] es; logic [1:0] ea; logic er, ey, eg, ee;
      @(posedge clk); #1;
      model(n_edges, es, ea, er, ey, eg, ee);
      n_checks++;
      if ({seg, an} !== {es, ea})
        $display("FAIL async_resume n %0d got %b/%b want %b/%b", n_edges, seg, an, es, ea);
      else n_pass++;
      if (i == 1) begin
        n_checks++;
        if (an !== 2'b10) $display("FAIL async_units got %b want 10", an); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_digit();
    test_tens_blank();
    test_yellow_blink();
    test_illegal();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
